// File: rtl/seven_segment_display_scheduler.sv
// rtl/seven_segment_display_scheduler.sv - 4-digit multiplexed 7-segment display scheduler
//
// Drives a 4-digit common-anode display one digit per slot. Each slot starts
// with DEADTIME dark cycles, followed by a PWM on-window sized by the latched
// brightness. A new hex value and blank mask arrive through a valid/ready
// handshake into a shadow buffer. The shadow becomes active only at a frame
// boundary, so a frame never shows a mix of old and new contents.
//
// Ports:
//   CLK          system clock
//   reset        asynchronous, active-high reset
//   load_valid   upstream offers load_value/load_blank
//   load_ready   shadow buffer free (transfer on load_valid & load_ready)
//   load_value   four hex digits, [3:0] = digit0 .. [15:12] = digit3
//   load_blank   per-digit blank mask, 1 = dark, bit n = digit n
//   brightness   on-window in 16ths of a slot, sampled at slot start
//   anode        one-hot digit enable, active-high, bit n = digit n
//   segments     active-low segments, [6]=a .. [0]=g
//   frame_strobe one-cycle pulse after the last cycle of the digit3 slot
module seven_segment_display_scheduler #(
  parameter int DIGIT_PERIOD_LOG2 = 14,
  parameter int DEADTIME          = 64
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  load_blank,
  input  logic [3:0]  brightness,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        frame_strobe
);

  localparam int N = DIGIT_PERIOD_LOG2;
  localparam logic [N-1:0] DEAD = N'(DEADTIME);
  localparam logic [N-1:0] ONE  = N'(1);

  logic [N-1:0] slot_count;
  logic [1:0]   digit_idx;
  logic [3:0]   bright_latched;

  logic [15:0]  value_active;
  logic [3:0]   blank_active;
  logic [15:0]  shadow_value;
  logic [3:0]   shadow_blank;
  logic         pending;

  logic         boundary;
  logic         accept;
  logic         lit;
  logic [3:0]   cur_nibble;
  logic [6:0]   cur_seg;
  logic [3:0]   cur_anode;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b1110010;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign load_ready = ~pending;
  assign accept     = load_valid & ~pending;
  assign boundary   = (digit_idx == 2'd3) & (&slot_count);

  always_comb begin
    cur_nibble = value_active[{digit_idx, 2'b00} +: 4];
    cur_seg    = hex_decode(cur_nibble);
    cur_anode  = 4'b0001 << digit_idx;
    // The top four bits of slot_count give the 16th of the slot we are in,
    // so comparing against brightness yields a (brightness+1)/16 window.
    lit = (slot_count >= DEAD)
        & (slot_count[N-1:N-4] <= bright_latched)
        & ~blank_active[digit_idx];
  end

  // Slot and digit sequencing; brightness is only picked up at slot start.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slot_count     <= '0;
      digit_idx      <= 2'd0;
      bright_latched <= 4'd0;
    end else begin
      slot_count <= slot_count + ONE;
      if (&slot_count) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (slot_count == '0) begin
        bright_latched <= brightness;
      end
    end
  end

  // Shadow buffer and frame-boundary commit. Accept requires pending==0 and
  // commit requires pending==1, so the two never collide: a word accepted
  // on the boundary cycle waits for the following boundary.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      value_active <= 16'h0000;
      blank_active <= 4'hF;
      shadow_value <= 16'h0000;
      shadow_blank <= 4'h0;
      pending      <= 1'b0;
    end else begin
      if (boundary && pending) begin
        value_active <= shadow_value;
        blank_active <= shadow_blank;
        pending      <= 1'b0;
      end
      if (accept) begin
        shadow_value <= load_value;
        shadow_blank <= load_blank;
        pending      <= 1'b1;
      end
    end
  end

  // Registered outputs. Dead time at the start of every slot guarantees an
  // all-off gap between consecutive digits.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      anode        <= 4'b0000;
      segments     <= 7'h7F;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= boundary;
      if (lit) begin
        anode    <= cur_anode;
        segments <= cur_seg;
      end else begin
        anode    <= 4'b0000;
        segments <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_display_scheduler.sv
// tb/tb_seven_segment_display_scheduler.sv - self-checking bench for seven_segment_display_scheduler
module tb_seven_segment_display_scheduler;

  localparam int LOG2  = 6;
  localparam int DT    = 2;
  localparam int SLOT  = 1 << LOG2;
  localparam int FRAME = 4 * SLOT;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = 16'h0;
  logic [3:0]  load_blank = 4'h0;
  logic [3:0]  brightness = 4'h0;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic        frame_strobe;

  always #5 CLK = ~CLK;

  seven_segment_display_scheduler #(
    .DIGIT_PERIOD_LOG2(LOG2),
    .DEADTIME(DT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .load_blank(load_blank),
    .brightness(brightness),
    .anode(anode),
    .segments(segments),
    .frame_strobe(frame_strobe)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_table [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: time since reset release in cycles, plus active/shadow.
  int          cyc;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_blank, m_sh_blank, m_bright;
  bit          m_pending;
  bit          m_accepted;
  logic [3:0]  last_lit;
  int          dark_run;
  int          lit_cnt [4];

  task automatic model_reset();
    cyc = 0;
    m_val = 16'h0; m_blank = 4'hF;
    m_sh_val = 16'h0; m_sh_blank = 4'h0;
    m_bright = 4'h0; m_pending = 0; m_accepted = 0;
    last_lit = 4'h0; dark_run = 0;
  endtask

  task automatic step();
    int phase, dig;
    bit lit, bnd;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    phase = cyc % SLOT;
    dig   = (cyc / SLOT) % 4;
    n_vec++;
    if (load_ready !== !m_pending) begin
      n_err++;
      $display("FAIL load_ready cyc=%0d got %b want %b", cyc, load_ready, !m_pending);
    end
    bnd = (dig == 3) && (phase == SLOT - 1);
    lit = (phase >= DT) && ((phase / (SLOT / 16)) <= int'(m_bright)) && !m_blank[dig];
    exp_an  = lit ? 4'(1 << dig) : 4'b0000;
    exp_seg = lit ? seg_table[m_val[4*dig +: 4]] : 7'h7F;
    if (phase == 0) m_bright = brightness;
    m_accepted = load_valid && !m_pending;
    if (bnd && m_pending) begin
      m_val = m_sh_val; m_blank = m_sh_blank; m_pending = 0;
    end
    if (m_accepted) begin
      m_sh_val = load_value; m_sh_blank = load_blank; m_pending = 1;
    end
    cyc++;
    @(posedge CLK); #1;
    n_vec++;
    if (anode !== exp_an) begin
      n_err++;
      $display("FAIL anode cyc=%0d got %b want %b", cyc - 1, anode, exp_an);
    end
    n_vec++;
    if (segments !== exp_seg) begin
      n_err++;
      $display("FAIL segments cyc=%0d got %b want %b", cyc - 1, segments, exp_seg);
    end
    n_vec++;
    if (frame_strobe !== bnd) begin
      n_err++;
      $display("FAIL frame_strobe cyc=%0d got %b want %b", cyc - 1, frame_strobe, bnd);
    end
    n_vec++;
    if ($countones(anode) > 1) begin
      n_err++;
      $display("FAIL onehot cyc=%0d got %b want at most one bit", cyc - 1, anode);
    end
    if (anode !== 4'b0000) begin
      if (last_lit != 4'b0000 && anode !== last_lit) begin
        n_vec++;
        if (dark_run < 2) begin
          n_err++;
          $display("FAIL dead_gap cyc=%0d got %0d dark cycles want >=2", cyc - 1, dark_run);
        end
      end
      last_lit = anode;
      dark_run = 0;
    end else begin
      dark_run++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b);
    int n = 0;
    load_valid = 1'b1; load_value = v; load_blank = b;
    do begin step(); n++; end while (!m_accepted && n < 2 * FRAME);
    load_valid = 1'b0;
    n_vec++;
    if (!m_accepted) begin
      n_err++;
      $display("FAIL load_timeout got no accept want accept within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin step(); n++; end while (frame_strobe !== 1'b1 && n < FRAME + 4);
    n_vec++;
    if (frame_strobe !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_timeout got %b want 1", frame_strobe);
    end
  endtask

  task automatic count_frame();
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      for (int d = 0; d < 4; d++) if (anode[d] === 1'b1) lit_cnt[d]++;
    end
  endtask

  task automatic test_reset();
    int strobes = 0;
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (anode !== 4'b0 || segments !== 7'h7F || load_ready !== 1'b1 || frame_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got an=%b seg=%h rdy=%b fs=%b want 0000/7f/1/0",
               anode, segments, load_ready, frame_strobe);
    end
    reset = 1'b0;
    model_reset();
    brightness = 4'($urandom);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_strobe === 1'b1) strobes++;
    end
    n_vec++;
    if (strobes != 2) begin
      n_err++;
      $display("FAIL strobe_count got %0d want 2", strobes);
    end
  endtask

  task automatic test_decode();
    brightness = 4'hF;
    do_load(16'h1208, 4'h0);
    wait_strobe();
    count_frame();
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (lit_cnt[d] != SLOT - DT) begin
        n_err++;
        $display("FAIL lit_cycles digit%0d got %0d want %0d", d, lit_cnt[d], SLOT - DT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bit seen = 0;
    brightness = 4'hF;
    do_load(16'($urandom), 4'h0);
    load_valid = 1'b1; load_value = 16'($urandom); load_blank = 4'h0;
    do begin
      step(); n++;
      if (!m_accepted && frame_strobe === 1'b1) seen = 1;
    end while (!m_accepted && n < 2 * FRAME);
    load_valid = 1'b0;
    n_vec++;
    if (!m_accepted || !seen) begin
      n_err++;
      $display("FAIL b2b_accept got accepted=%0d strobe_before=%0d want 1/1", m_accepted, seen);
    end
    wait_strobe();
    count_frame();
  endtask

  task automatic test_brightness();
    brightness = 4'h0;
    do_load(16'($urandom), 4'h0);
    wait_strobe();
    count_frame();
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (lit_cnt[d] != 2) begin
        n_err++;
        $display("FAIL bright0 digit%0d got %0d want 2", d, lit_cnt[d]);
      end
    end
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 30) brightness = 4'h7;
      step();
      for (int d = 0; d < 4; d++) if (anode[d] === 1'b1) lit_cnt[d]++;
    end
    n_vec++;
    if (lit_cnt[0] != 2 || lit_cnt[1] != 30 || lit_cnt[2] != 30 || lit_cnt[3] != 30) begin
      n_err++;
      $display("FAIL bright_change got %0d/%0d/%0d/%0d want 2/30/30/30",
               lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
    end
  endtask

  task automatic test_blank_and_boundary();
    brightness = 4'hF;
    do_load(16'($urandom), 4'b1010);
    wait_strobe();
    count_frame();
    n_vec++;
    if (lit_cnt[0] != 62 || lit_cnt[1] != 0 || lit_cnt[2] != 62 || lit_cnt[3] != 0) begin
      n_err++;
      $display("FAIL blank_mask got %0d/%0d/%0d/%0d want 62/0/62/0",
               lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
    end
    while ((cyc % FRAME) != FRAME - 1) step();
    load_valid = 1'b1; load_value = 16'($urandom); load_blank = 4'h0;
    step();
    load_valid = 1'b0;
    count_frame();
    n_vec++;
    if (lit_cnt[1] != 0 || lit_cnt[3] != 0) begin
      n_err++;
      $display("FAIL boundary_hold got d1=%0d d3=%0d want 0/0", lit_cnt[1], lit_cnt[3]);
    end
    count_frame();
    n_vec++;
    if (lit_cnt[1] != 62 || lit_cnt[3] != 62) begin
      n_err++;
      $display("FAIL boundary_next got d1=%0d d3=%0d want 62/62", lit_cnt[1], lit_cnt[3]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int lit_after = 0;
    brightness = 4'hF;
    do_load(16'($urandom), 4'h0);
    do begin step(); n++; end while (anode === 4'b0000 && n < FRAME);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (anode !== 4'b0000 || segments !== 7'h7F || load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset got an=%b seg=%h rdy=%b want 0000/7f/1", anode, segments, load_ready);
    end
    @(posedge CLK); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (anode !== 4'b0000) lit_after++;
    end
    n_vec++;
    if (lit_after != 0) begin
      n_err++;
      $display("FAIL stale_commit got %0d lit cycles want 0", lit_after);
    end
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 6; k++) begin
      brightness = 4'($urandom);
      do_load(16'($urandom), 4'($urandom));
      len = $urandom_range(50, 400);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
        step();
      end
    end
    count_frame();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_decode();
    test_back_to_back();
    test_brightness();
    test_blank_and_boundary();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
